cpu_phase_ctrl: RTL and testbench
=================================

# cpu_phase_ctrl

Single-clock phase sequencer for the RISC-V core. It replaces the free-running phase clocks (fetch, ALU, RAM, register) with one-cycle enable strobes generated by an FSM. It stretches the execute phase for multi-cycle mul/div until the ALU reports completion, and stretches the memory phase until RAM/IO acknowledges. It sits beside the decoder/control logic and drives the enables of PC, registers, decoder, ALU and the RAM/IO port.

## Interface
Parameters:
- MD_TIMEOUT, 64: maximum cycles spent waiting for `alu_complete` before a fault is raised; legal range 2..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; free-running execution while high.
- step  in  1  pulse; executes exactly one instruction when parked in IDLE with `run`=0.
- is_md  in  1  decoded instruction is mul/div; sampled in DECODE.
- is_mem  in  1  decoded instruction is load/store; sampled in DECODE.
- alu_complete  in  1  level from ALU; multi-cycle op finished.
- mem_ready  in  1  RAM/IO access acknowledge.
- fetch_en  out  1  ROM address/instruction latch strobe.
- dec_en  out  1  decoder latch strobe.
- alu_en  out  1  ALU operand latch strobe.
- md_start  out  1  one-cycle mul/div start pulse.
- mem_en  out  1  RAM/IO access request; held until `mem_ready`.
- wb_en  out  1  register write and PC update strobe.
- busy  out  1  high whenever state is not IDLE.
- md_fault  out  1  sticky; set on mul/div timeout.
- state_o  out  3  current state encoding.
- cycle_cnt, instret_cnt  out  CNT_W  only present with CPU_PHASE_PERF_EN.

## Operation
State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MD_WAIT=4, MEM=5, WB=6, FAULT=7.

Transitions and actions:
- IDLE:
  - `run`=1 goes to FETCH.
  - `run`=0 with `step`=1 goes to FETCH and sets an internal `single` flag.
- FETCH: `fetch_en`=1; goes to DECODE.
- DECODE: `dec_en`=1; latches `is_md` and `is_mem`; goes to EXEC.
- EXEC: `alu_en`=1.
  - If md: `md_start`=1, clears the wait counter, goes to MD_WAIT.
  - Else if mem: goes to MEM.
  - Else: goes to WB.
- MD_WAIT: increments the wait counter each cycle.
  - `alu_complete`=1 goes to WB.
  - Else, counter == MD_TIMEOUT-1 goes to FAULT.
  - If both occur in the same cycle, `alu_complete` wins.
- MEM: `mem_en`=1; `mem_ready`=1 goes to WB.
- WB: `wb_en`=1.
  - If `run`=1 and `single`=0: goes to FETCH.
  - Otherwise: clears `single` and goes to IDLE.
- FAULT: `md_fault`=1; all strobes 0; leaves only on `rst`.

Boundary rules:
- `is_md` and `is_mem` both high: md takes priority and MEM is skipped. Such an instruction is illegal by decode.
- `alu_complete` outside MD_WAIT is ignored.
- `mem_ready` outside MEM is ignored.
- `step` outside IDLE, or with `run`=1, is ignored.
- Dropping `run` mid-instruction does not abort; the instruction retires through WB, then the FSM enters IDLE.
- All strobes are one-hot, derived combinationally from state. At most one of fetch/dec/alu/mem/wb is high per cycle.

## Timing
- Reset: state IDLE; every output 0; counters 0; `single`=0; `md_fault`=0.
- Plain ALU/branch instruction: FETCH→WB in 4 cycles. Back-to-back throughput is 1 instruction per 4 cycles.
- Load/store: 5 cycles plus (N-1), where N is the cycle count until `mem_ready`.
- Mul/div: 4 cycles plus the number of MD_WAIT cycles (minimum 1).
- Fault: declared after exactly MD_TIMEOUT cycles in MD_WAIT without completion.
- Resume from IDLE: FETCH is entered the cycle after `run` or `step` is seen.

## Configuration
- CPU_PHASE_PERF_EN defined:
  - Adds `cycle_cnt`, which increments every cycle state ∉ {IDLE, FAULT}.
  - Adds `instret_cnt`, which increments on every `wb_en`.
  - Both wrap modulo 2^CNT_W and are cleared by `rst`.
- Undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

## Structure
- Package `cpu_phase_pkg` holds the state typedef and encodings, plus MD_TIMEOUT range constants.
- One sub-module, `cpu_phase_wdog`:
  - Contains the MD_WAIT counter.
  - Inputs: clear and enable.
  - Output: expire.
- The FSM stays in `cpu_phase_ctrl`.

## Test plan
- Reset, then `run`=1 with is_md=is_mem=0 for 3 instructions: states 1,2,3,6 repeat; `wb_en` pulses at cycles 4, 8, 12; instret_cnt=3.
- Load with `mem_ready` at the 3rd MEM cycle: `mem_en` high for 3 cycles; `wb_en` 7 cycles after FETCH entry.
- Mul/div with `alu_complete` after 10 MD_WAIT cycles: `md_start` is a single pulse in EXEC; WB follows; no fault.
- Mul/div with MD_TIMEOUT=8 and no `alu_complete`: FAULT entered after 8 MD_WAIT cycles; `md_fault`=1 sticky; `run` has no effect; `rst` clears to IDLE.
- `run`=0, `step` pulse: exactly one instruction, return to IDLE, `busy` low. A second `step` held during execution is ignored.
- Drop `run` during MD_WAIT: the instruction completes through WB, then IDLE. Assert `rst` in MEM: next cycle IDLE with all outputs 0.

Source files
------------

// File: rtl/cpu_phase_pkg.sv
// Shared types and constants for the cpu_phase_ctrl phase sequencer.
// The state encoding is visible on state_o, so the values are fixed.
package cpu_phase_pkg;

    localparam int unsigned STATE_W        = 3;
    localparam int unsigned WDOG_W         = 8;
    localparam int unsigned MD_TIMEOUT_MIN = 2;
    localparam int unsigned MD_TIMEOUT_MAX = 255;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MD_WAIT = 3'd4,
        ST_MEM     = 3'd5,
        ST_WB      = 3'd6,
        ST_FAULT   = 3'd7
    } state_e;

endpackage

// File: rtl/cpu_phase_wdog.sv
// Mul/div wait counter. expire is high on the MD_TIMEOUT-th enabled cycle
// after a clear, so the FSM can fault without spending an extra cycle.
module cpu_phase_wdog
    import cpu_phase_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == WDOG_W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Phase sequencer: one-hot enable strobes for fetch/decode/ALU/mem/writeback.
// Define CPU_PHASE_PERF_EN to add the cycle_cnt / instret_cnt counters.
module cpu_phase_ctrl
    import cpu_phase_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               is_md,
    input  logic               is_mem,
    input  logic               alu_complete,
    input  logic               mem_ready,
    output logic               fetch_en,
    output logic               dec_en,
    output logic               alu_en,
    output logic               md_start,
    output logic               mem_en,
    output logic               wb_en,
    output logic               busy,
    output logic               md_fault,
    output logic [STATE_W-1:0] state_o
`ifdef CPU_PHASE_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
`endif
);

    if ((MD_TIMEOUT < MD_TIMEOUT_MIN) || (MD_TIMEOUT > MD_TIMEOUT_MAX)) begin : g_bad_md_timeout
        $error("cpu_phase_ctrl: MD_TIMEOUT out of range");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("cpu_phase_ctrl: CNT_W must be non-zero");
    end

    state_e state_q;
    state_e state_d;
    logic   single_q;
    logic   single_d;
    logic   md_q;
    logic   md_d;
    logic   mem_q;
    logic   mem_d;

    logic   fetch_en_c;
    logic   dec_en_c;
    logic   alu_en_c;
    logic   md_start_c;
    logic   mem_en_c;
    logic   wb_en_c;
    logic   md_fault_c;
    logic   wdog_en_c;
    logic   wdog_expire;

    cpu_phase_wdog #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (md_start_c),
        .enable (wdog_en_c),
        .expire (wdog_expire)
    );

    // Next-state and strobe decode; strobes depend on the current state only.
    always_comb begin
        state_d    = state_q;
        single_d   = single_q;
        md_d       = md_q;
        mem_d      = mem_q;
        fetch_en_c = 1'b0;
        dec_en_c   = 1'b0;
        alu_en_c   = 1'b0;
        md_start_c = 1'b0;
        mem_en_c   = 1'b0;
        wb_en_c    = 1'b0;
        md_fault_c = 1'b0;
        wdog_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step) begin
                    state_d  = ST_FETCH;
                    single_d = 1'b1;
                end
            end
            ST_FETCH: begin
                fetch_en_c = 1'b1;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                dec_en_c = 1'b1;
                md_d     = is_md;
                mem_d    = is_mem;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                alu_en_c = 1'b1;
                // mul/div wins over a (decode-illegal) simultaneous mem flag
                if (md_q) begin
                    md_start_c = 1'b1;
                    state_d    = ST_MD_WAIT;
                end else if (mem_q) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MD_WAIT: begin
                wdog_en_c = 1'b1;
                if (alu_complete) begin
                    state_d = ST_WB;
                end else if (wdog_expire) begin
                    state_d = ST_FAULT;
                end
            end
            ST_MEM: begin
                mem_en_c = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                wb_en_c = 1'b1;
                if (run && !single_q) begin
                    state_d = ST_FETCH;
                end else begin
                    single_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_FAULT: begin
                md_fault_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            single_q <= 1'b0;
            md_q     <= 1'b0;
            mem_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            md_q     <= md_d;
            mem_q    <= mem_d;
        end
    end

    assign fetch_en = fetch_en_c;
    assign dec_en   = dec_en_c;
    assign alu_en   = alu_en_c;
    assign md_start = md_start_c;
    assign mem_en   = mem_en_c;
    assign wb_en    = wb_en_c;
    assign md_fault = md_fault_c;
    assign busy     = (state_q != ST_IDLE);
    assign state_o  = STATE_W'(state_q);

`ifdef CPU_PHASE_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q;
    logic [CNT_W-1:0] instret_cnt_d;

    // Active cycles exclude IDLE and FAULT; both counters wrap naturally.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if ((state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (wb_en_c) begin
            instret_cnt_d = instret_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed bench for cpu_phase_ctrl; counter checks only with CPU_PHASE_PERF_EN.
module tb_cpu_phase_ctrl;

    localparam int unsigned MD_TO = 12;
    localparam int unsigned CW    = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       step;
    logic       is_md;
    logic       is_mem;
    logic       alu_complete;
    logic       mem_ready;
    logic       fetch_en;
    logic       dec_en;
    logic       alu_en;
    logic       md_start;
    logic       mem_en;
    logic       wb_en;
    logic       busy;
    logic       md_fault;
    logic [2:0] state_o;
`ifdef CPU_PHASE_PERF_EN
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] obs;
    assign obs = {fetch_en, dec_en, alu_en, md_start, mem_en, wb_en, busy, md_fault};

    always #5 clk = ~clk;

    cpu_phase_ctrl #(
        .MD_TIMEOUT (MD_TO),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step         (step),
        .is_md        (is_md),
        .is_mem       (is_mem),
        .alu_complete (alu_complete),
        .mem_ready    (mem_ready),
        .fetch_en     (fetch_en),
        .dec_en       (dec_en),
        .alu_en       (alu_en),
        .md_start     (md_start),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .busy         (busy),
        .md_fault     (md_fault),
        .state_o      (state_o)
`ifdef CPU_PHASE_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    // Expected {fetch,dec,alu,md_start,mem,wb,busy,md_fault} for a state.
    function automatic logic [7:0] exp_vec(input logic [2:0] st, input logic md);
        case (st)
            3'd0:    exp_vec = 8'b0000_0000;
            3'd1:    exp_vec = 8'b1000_0010;
            3'd2:    exp_vec = 8'b0100_0010;
            3'd3:    exp_vec = md ? 8'b0011_0010 : 8'b0010_0010;
            3'd4:    exp_vec = 8'b0000_0010;
            3'd5:    exp_vec = 8'b0000_1010;
            3'd6:    exp_vec = 8'b0000_0110;
            default: exp_vec = 8'b0000_0011;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; is_md = 1'b0; is_mem = 1'b0;
        alu_complete = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state_o !== 3'd0) begin
            errors++; $display("FAIL reset state_o: got %0d expected 0", state_o);
        end
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL reset outputs: got %b expected 00000000", obs);
        end
`ifdef CPU_PHASE_PERF_EN
        checks++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            errors++; $display("FAIL reset counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
`endif
        tick();
        checks++;
        if (state_o !== 3'd0 || obs !== 8'h00) begin
            errors++; $display("FAIL reset idle_hold: got state %0d outputs %b expected 0 00000000", state_o, obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            case ((i - 1) % 4)
                0:       e = 3'd1;
                1:       e = 3'd2;
                2:       e = 3'd3;
                default: e = 3'd6;
            endcase
            checks++;
            if (state_o !== e) begin
                errors++; $display("FAIL b2b c%0d state_o: got %0d expected %0d", i, state_o, e);
            end
            checks++;
            if (obs !== exp_vec(e, 1'b0)) begin
                errors++; $display("FAIL b2b c%0d outputs: got %b expected %b", i, obs, exp_vec(e, 1'b0));
            end
        end
        run = 1'b0;
        tick();
        checks++;
        if (state_o !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b stop: got state %0d busy %b expected 0 0", state_o, busy);
        end
`ifdef CPU_PHASE_PERF_EN
        checks++;
        if (instret_cnt !== CW'(3) || cycle_cnt !== CW'(12)) begin
            errors++; $display("FAIL b2b counters: got instret %0d cycles %0d expected 3 12", instret_cnt, cycle_cnt);
        end
`endif
    endtask

    task automatic test_load();
        logic [2:0] exp_tab [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd5, 3'd6, 3'd0};
        int mem_cnt = 0;
        int wb_cyc  = 0;
        do_reset();
        is_mem       = 1'b1;
        alu_complete = 1'b1;
        run          = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (state_o !== exp_tab[i-1] || obs !== exp_vec(exp_tab[i-1], 1'b0)) begin
                errors++; $display("FAIL load c%0d: got state %0d outputs %b expected %0d %b",
                                   i, state_o, obs, exp_tab[i-1], exp_vec(exp_tab[i-1], 1'b0));
            end
            if (mem_en === 1'b1) mem_cnt++;
            if (wb_en === 1'b1 && wb_cyc == 0) wb_cyc = i;
            if (i == 1) run = 1'b0;
            if (i == 6) mem_ready = 1'b1;
            if (i == 7) mem_ready = 1'b0;
        end
        checks++;
        if (mem_cnt != 3) begin
            errors++; $display("FAIL load mem_en_cycles: got %0d expected 3", mem_cnt);
        end
        checks++;
        if (wb_cyc != 7) begin
            errors++; $display("FAIL load wb_cycle: got %0d expected 7", wb_cyc);
        end
    endtask

    task automatic test_md_complete();
        logic [2:0] e;
        int md_cnt = 0;
        do_reset();
        is_md        = 1'b1;
        alu_complete = 1'b1;
        run          = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i <= 3)       e = 3'(i);
            else if (i <= 13) e = 3'd4;
            else if (i == 14) e = 3'd6;
            else              e = 3'd0;
            checks++;
            if (state_o !== e || obs !== exp_vec(e, 1'b1)) begin
                errors++; $display("FAIL md_done c%0d: got state %0d outputs %b expected %0d %b",
                                   i, state_o, obs, e, exp_vec(e, 1'b1));
            end
            if (md_start === 1'b1) md_cnt++;
            if (i == 3)  alu_complete = 1'b0;
            if (i == 6)  run = 1'b0;
            if (i == 13) alu_complete = 1'b1;
            if (i == 14) alu_complete = 1'b0;
        end
        checks++;
        if (md_cnt != 1) begin
            errors++; $display("FAIL md_done md_start_pulses: got %0d expected 1", md_cnt);
        end
    endtask

    task automatic test_md_tie();
        logic [2:0] e;
        do_reset();
        is_md  = 1'b1;
        is_mem = 1'b1;
        run    = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i <= 3)       e = 3'(i);
            else if (i <= 15) e = 3'd4;
            else if (i == 16) e = 3'd6;
            else              e = 3'd0;
            checks++;
            if (state_o !== e || obs !== exp_vec(e, 1'b1)) begin
                errors++; $display("FAIL md_tie c%0d: got state %0d outputs %b expected %0d %b",
                                   i, state_o, obs, e, exp_vec(e, 1'b1));
            end
            if (i == 1)  run = 1'b0;
            if (i == 15) alu_complete = 1'b1;
            if (i == 16) alu_complete = 1'b0;
        end
    endtask

    task automatic test_md_fault();
        logic [2:0] e;
        do_reset();
        is_md = 1'b1;
        run   = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= 3)       e = 3'(i);
            else if (i <= 15) e = 3'd4;
            else              e = 3'd7;
            checks++;
            if (state_o !== e || obs !== exp_vec(e, 1'b1)) begin
                errors++; $display("FAIL md_fault c%0d: got state %0d outputs %b expected %0d %b",
                                   i, state_o, obs, e, exp_vec(e, 1'b1));
            end
            if (i == 16) begin
                step = 1'b1; alu_complete = 1'b1; mem_ready = 1'b1;
            end
        end
`ifdef CPU_PHASE_PERF_EN
        checks++;
        if (cycle_cnt !== CW'(15) || instret_cnt !== '0) begin
            errors++; $display("FAIL md_fault counters: got cycles %0d instret %0d expected 15 0", cycle_cnt, instret_cnt);
        end
`endif
        rst = 1'b1;
        tick();
        checks++;
        if (state_o !== 3'd0 || obs !== 8'h00) begin
            errors++; $display("FAIL md_fault rst_clear: got state %0d outputs %b expected 0 00000000", state_o, obs);
        end
        rst = 1'b0; run = 1'b0; step = 1'b0; alu_complete = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_step();
        logic [2:0] exp_tab [11] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd0,
                                     3'd1, 3'd2, 3'd3, 3'd6, 3'd1};
        do_reset();
        step = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks++;
            if (state_o !== exp_tab[i-1] || obs !== exp_vec(exp_tab[i-1], 1'b0)) begin
                errors++; $display("FAIL step c%0d: got state %0d outputs %b expected %0d %b",
                                   i, state_o, obs, exp_tab[i-1], exp_vec(exp_tab[i-1], 1'b0));
            end
            if (i == 1) step = 1'b0;
            if (i == 2) step = 1'b1;
            if (i == 4) step = 1'b0;
            if (i == 6) run  = 1'b1;
        end
        run = 1'b0;
    endtask

    task automatic test_rst_in_mem();
        do_reset();
        is_mem = 1'b1;
        run    = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        checks++;
        if (state_o !== 3'd5) begin
            errors++; $display("FAIL rst_mem enter: got state %0d expected 5", state_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (state_o !== 3'd0 || obs !== 8'h00) begin
            errors++; $display("FAIL rst_mem clear: got state %0d outputs %b expected 0 00000000", state_o, obs);
        end
`ifdef CPU_PHASE_PERF_EN
        checks++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            errors++; $display("FAIL rst_mem counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
`endif
        rst = 1'b0; run = 1'b0; is_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load();
        test_md_complete();
        test_md_tie();
        test_md_fault();
        test_step();
        test_rst_in_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
